// File: rtl/text_column_sequencer.sv
// Glyph-column scheduler: holds a host-loaded ring of character codes and,
// while run is high, walks each glyph's ROM columns followed by blank gap
// columns, looping over the message with no dead cycles.
module text_column_sequencer #(
    parameter  int WORD_COUNT = 32,
    parameter  int CHAR_COLS  = 6,
    parameter  int GAP_COLS   = 2,
    localparam int LW         = $clog2(WORD_COUNT + 1),
    localparam int IW         = $clog2(WORD_COUNT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [6:0]    i_wr_char,
    input  logic          i_clear,
    input  logic          i_run,
    output logic [6:0]    o_rom_char,
    output logic [2:0]    o_rom_col,
    input  logic [7:0]    i_rom_data,
    output logic [7:0]    o_col_out,
    output logic          o_col_valid,
    output logic          o_frame_start,
    output logic          o_full,
    output logic [LW-1:0] o_len
);

    typedef enum logic [1:0] {S_IDLE, S_GLYPH, S_GAP} state_t;

    state_t          r_state, w_state_nx;
    logic [6:0]      r_buf [WORD_COUNT];
    logic [LW-1:0]   r_len;
    logic [IW-1:0]   r_rd_idx, w_rd_idx_nx;
    logic [2:0]      r_col_cnt, w_col_cnt_nx;
    logic [2:0]      r_gap_cnt, w_gap_cnt_nx;
    logic [7:0]      r_col_out, w_col_out_nx;
    logic            r_col_valid, w_col_valid_nx;
    logic            r_frame_start, w_frame_start_nx;
    logic            w_wr_ok, w_last_char, w_glyph_end, w_gap_end, w_boundary;

    // Host writes land at index len; only possible while idle and not full.
    assign o_full      = (r_len == LW'(WORD_COUNT));
    assign w_wr_ok     = (r_state == S_IDLE) && !i_clear && i_wr_en && !o_full;
    assign w_last_char = (LW'(r_rd_idx) == r_len - LW'(1));
    assign w_glyph_end = (r_state == S_GLYPH) && (r_col_cnt == 3'(CHAR_COLS - 1));
    assign w_gap_end   = (r_state == S_GAP) && (r_gap_cnt == 3'(GAP_COLS - 1));
    // With no gap columns the glyph's last column is itself the boundary.
    assign w_boundary  = (GAP_COLS == 0) ? w_glyph_end : w_gap_end;

    // ROM is only addressed while fetching a glyph; it sees zeros otherwise.
    assign o_rom_char    = (r_state == S_GLYPH) ? r_buf[r_rd_idx] : 7'd0;
    assign o_rom_col     = (r_state == S_GLYPH) ? r_col_cnt : 3'd0;
    assign o_col_out     = r_col_out;
    assign o_col_valid   = r_col_valid;
    assign o_frame_start = r_frame_start;
    assign o_len         = r_len;

    // Message storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_buf[r_len[IW-1:0]] <= i_wr_char;
    end

    // Buffer length: clear beats a simultaneous write, both ignored while streaming.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                  r_len <= '0;
        else if (r_state == S_IDLE && i_clear)      r_len <= '0;
        else if (w_wr_ok)                           r_len <= r_len + LW'(1);
    end

    // Sequencer state and registered column outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rd_idx      <= '0;
            r_col_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_col_out     <= '0;
            r_col_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_rd_idx      <= w_rd_idx_nx;
            r_col_cnt     <= w_col_cnt_nx;
            r_gap_cnt     <= w_gap_cnt_nx;
            r_col_out     <= w_col_out_nx;
            r_col_valid   <= w_col_valid_nx;
            r_frame_start <= w_frame_start_nx;
        end
    end

    // Next-state and next-column logic; run is only honoured at glyph boundaries.
    always_comb begin
        w_state_nx       = r_state;
        w_rd_idx_nx      = r_rd_idx;
        w_col_cnt_nx     = r_col_cnt;
        w_gap_cnt_nx     = r_gap_cnt;
        w_col_out_nx     = 8'd0;
        w_col_valid_nx   = 1'b0;
        w_frame_start_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run && r_len != '0) begin
                    w_state_nx   = S_GLYPH;
                    w_rd_idx_nx  = '0;
                    w_col_cnt_nx = '0;
                end
            end
            S_GLYPH: begin
                w_col_out_nx     = i_rom_data;
                w_col_valid_nx   = 1'b1;
                w_frame_start_nx = (r_rd_idx == '0) && (r_col_cnt == '0);
                w_col_cnt_nx     = r_col_cnt + 3'd1;
                if (w_glyph_end) begin
                    w_col_cnt_nx = '0;
                    w_gap_cnt_nx = '0;
                    if (GAP_COLS > 0) w_state_nx = S_GAP;
                end
            end
            S_GAP: begin
                w_col_valid_nx = 1'b1;
                w_gap_cnt_nx   = r_gap_cnt + 3'd1;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_boundary) begin
            if (!i_run) begin
                w_state_nx = S_IDLE;
            end else begin
                w_state_nx   = S_GLYPH;
                w_rd_idx_nx  = w_last_char ? '0 : r_rd_idx + IW'(1);
                w_col_cnt_nx = '0;
            end
        end
    end

endmodule
